dm_sbus_ctrl: RTL

- Debug Module System Bus Manager controller: owns sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3c).
- Sequences single system-bus accesses triggered by debugger register accesses.
- Sits between the DM register decode (DMI side) and the system-bus fabric; reports errors through the sbcs fields using the debug package sberr/sbaccess encodings.

---
 rtl/dm_sbus_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dm_sbus_ctrl.sv
// dm_sbus_ctrl: Debug Module system bus manager.
// Owns sbcs (0x38), sbaddress0 (0x39) and sbdata0 (0x3c). Each qualifying
// debugger register access starts one single-beat system bus access.
// Optional feature macro: SBUS_TIMEOUT_EN. When it is defined, an access that
// sees no sb_ack within TIMEOUT_CYCLES is abandoned with sberror=1.
module dm_sbus_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              dmi_valid,
    input  logic              dmi_write,
    input  logic [7:0]        dmi_addr,
    input  logic [31:0]       dmi_wdata,
    output logic [31:0]       dmi_rdata,
    output logic              dmi_rvalid,
    output logic              sb_req,
    output logic              sb_we,
    output logic [ADDR_W-1:0] sb_addr,
    output logic [31:0]       sb_wdata,
    output logic [3:0]        sb_be,
    input  logic              sb_ack,
    input  logic              sb_err,
    input  logic [31:0]       sb_rdata
);

    // DM register addresses handled here
    localparam logic [7:0] ADDR_SBCS  = 8'h38;
    localparam logic [7:0] ADDR_SBADR = 8'h39;
    localparam logic [7:0] ADDR_SBDAT = 8'h3c;

    // sbaccess encodings
    localparam logic [2:0] SBACCESS_8  = 3'd0;
    localparam logic [2:0] SBACCESS_16 = 3'd1;
    localparam logic [2:0] SBACCESS_32 = 3'd2;

    // sberror encodings
    localparam logic [2:0] SBERR_NONE    = 3'd0;
    localparam logic [2:0] SBERR_BADADDR = 3'd2;
    localparam logic [2:0] SBERR_ALIGN   = 3'd3;
    localparam logic [2:0] SBERR_SIZE    = 3'd4;

`ifdef SBUS_TIMEOUT_EN
    localparam logic [2:0] SBERR_TIMEOUT = 3'd1;
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`else
    // Timeout is compiled out; keep the parameter referenced.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  sbaddress0_q, sbaddress0_d;
    logic [31:0]        sbdata0_q, sbdata0_d;
    logic [2:0]         access_q, access_d;
    logic               readonaddr_q, readonaddr_d;
    logic               readondata_q, readondata_d;
    logic               autoinc_q, autoinc_d;
    logic [2:0]         error_q, error_d;
    logic               busyerror_q, busyerror_d;
    logic               sb_we_q, sb_we_d;
    logic [ADDR_W-1:0]  sb_addr_q, sb_addr_d;
    logic [31:0]        sb_wdata_q, sb_wdata_d;
    logic [3:0]         sb_be_q, sb_be_d;
    logic [2:0]         acc_q, acc_d;
    logic [1:0]         lane_q, lane_d;
    logic [31:0]        rdata_cap_q, rdata_cap_d;
    logic               err_cap_q, err_cap_d;
    logic [31:0]        dmi_rdata_q, dmi_rdata_d;
    logic               dmi_rvalid_q, dmi_rvalid_d;
`ifdef SBUS_TIMEOUT_EN
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
`endif

    // Access decode
    logic              hit_sbcs, hit_adr, hit_dat;
    logic              wr_sbcs, wr_adr, wr_dat, rd_dat, rd_any;
    logic              busy, busy_viol, start_ok, trigger;
    logic              size_err, align_err;
    logic [ADDR_W-1:0] trig_addr;
    logic [3:0]        trig_be;
    logic [31:0]       trig_wdata;
    logic [31:0]       sbcs_rdata;
    logic [31:0]       rd_shift, rd_extract;

    assign hit_sbcs = dmi_valid && (dmi_addr == ADDR_SBCS);
    assign hit_adr  = dmi_valid && (dmi_addr == ADDR_SBADR);
    assign hit_dat  = dmi_valid && (dmi_addr == ADDR_SBDAT);
    assign wr_sbcs  = hit_sbcs && dmi_write;
    assign wr_adr   = hit_adr && dmi_write;
    assign wr_dat   = hit_dat && dmi_write;
    assign rd_dat   = hit_dat && !dmi_write;
    assign rd_any   = (hit_sbcs || hit_adr || hit_dat) && !dmi_write;

    // DONE still counts as busy so its register updates cannot be clobbered
    assign busy      = (state_q != ST_IDLE);
    assign busy_viol = busy && (wr_adr || wr_dat || rd_dat);
    assign start_ok  = !busyerror_q && (error_q == SBERR_NONE);
    assign trigger   = !busy && start_ok &&
                       ((wr_adr && readonaddr_q) || wr_dat || (rd_dat && readondata_q));

    // A write to sbaddress0 launches with the new address; others use the stored one
    assign trig_addr = wr_adr ? ADDR_W'(dmi_wdata) : sbaddress0_q;
    assign size_err  = (access_q > SBACCESS_32);
    assign align_err = ((access_q == SBACCESS_16) && trig_addr[0]) ||
                       ((access_q == SBACCESS_32) && (trig_addr[1:0] != 2'b00));
    assign trig_wdata = dmi_wdata << {trig_addr[1:0], 3'b000};

    // Per-lane byte enable from access size and low address bits
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign trig_be[gi] = (access_q == SBACCESS_32) ||
                                 ((access_q == SBACCESS_16) && (LANE[1] == trig_addr[1])) ||
                                 ((access_q == SBACCESS_8) && (LANE == trig_addr[1:0]));
        end
    endgenerate

    assign sbcs_rdata = {3'd1, 6'd0, busyerror_q, busy, readonaddr_q, access_q,
                         autoinc_q, readondata_q, error_q, 7'(ADDR_W), 5'b00111};

    // Move the addressed lane down to bit 0 and zero-extend by access size
    assign rd_shift = rdata_cap_q >> {lane_q, 3'b000};
    always_comb begin
        case (acc_q)
            SBACCESS_8:  rd_extract = {24'd0, rd_shift[7:0]};
            SBACCESS_16: rd_extract = {16'd0, rd_shift[15:0]};
            default:     rd_extract = rd_shift;
        endcase
    end

    // Register updates, DMI read response and access sequencing FSM
    always_comb begin
        state_d      = state_q;
        sbaddress0_d = sbaddress0_q;
        sbdata0_d    = sbdata0_q;
        access_d     = access_q;
        readonaddr_d = readonaddr_q;
        readondata_d = readondata_q;
        autoinc_d    = autoinc_q;
        error_d      = error_q;
        busyerror_d  = busyerror_q;
        sb_we_d      = sb_we_q;
        sb_addr_d    = sb_addr_q;
        sb_wdata_d   = sb_wdata_q;
        sb_be_d      = sb_be_q;
        acc_d        = acc_q;
        lane_d       = lane_q;
        rdata_cap_d  = rdata_cap_q;
        err_cap_d    = err_cap_q;
        dmi_rdata_d  = dmi_rdata_q;
        dmi_rvalid_d = 1'b0;
`ifdef SBUS_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif

        // Read data reflects register state before this cycle's updates
        if (rd_any) begin
            dmi_rvalid_d = 1'b1;
            if (hit_sbcs)     dmi_rdata_d = sbcs_rdata;
            else if (hit_adr) dmi_rdata_d = 32'(sbaddress0_q);
            else              dmi_rdata_d = sbdata0_q;
        end

        if (wr_sbcs) begin
            readonaddr_d = dmi_wdata[20];
            access_d     = dmi_wdata[19:17];
            autoinc_d    = dmi_wdata[16];
            readondata_d = dmi_wdata[15];
            busyerror_d  = busyerror_q & ~dmi_wdata[22];
            error_d      = error_q & ~dmi_wdata[14:12];
        end

        if (busy_viol) begin
            busyerror_d = 1'b1;
        end

        if (!busy) begin
            if (wr_adr) sbaddress0_d = ADDR_W'(dmi_wdata);
            if (wr_dat) sbdata0_d    = dmi_wdata;
        end

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    if (size_err) begin
                        error_d = SBERR_SIZE;
                    end else if (align_err) begin
                        error_d = SBERR_ALIGN;
                    end else begin
                        state_d    = ST_REQ;
                        sb_we_d    = wr_dat;
                        sb_addr_d  = {trig_addr[ADDR_W-1:2], 2'b00};
                        sb_be_d    = trig_be;
                        sb_wdata_d = wr_dat ? trig_wdata : 32'd0;
                        acc_d      = access_q;
                        lane_d     = trig_addr[1:0];
`ifdef SBUS_TIMEOUT_EN
                        to_cnt_d   = '0;
`endif
                    end
                end
            end
            ST_REQ: begin
                if (sb_ack) begin
                    state_d     = ST_DONE;
                    rdata_cap_d = sb_rdata;
                    err_cap_d   = sb_err;
`ifdef SBUS_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    error_d = SBERR_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
`endif
                end
            end
            ST_DONE: begin
                // Error set overrides a same-cycle W1C of sbcs
                state_d = ST_IDLE;
                if (err_cap_q) begin
                    error_d = SBERR_BADADDR;
                end else begin
                    if (!sb_we_q) sbdata0_d = rd_extract;
                    if (autoinc_q) sbaddress0_d = sbaddress0_q + (ADDR_W'(1) << acc_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            sbaddress0_q <= '0;
            sbdata0_q    <= '0;
            access_q     <= SBACCESS_32;
            readonaddr_q <= 1'b0;
            readondata_q <= 1'b0;
            autoinc_q    <= 1'b0;
            error_q      <= SBERR_NONE;
            busyerror_q  <= 1'b0;
            sb_we_q      <= 1'b0;
            sb_addr_q    <= '0;
            sb_wdata_q   <= '0;
            sb_be_q      <= '0;
            acc_q        <= SBACCESS_32;
            lane_q       <= '0;
            rdata_cap_q  <= '0;
            err_cap_q    <= 1'b0;
            dmi_rdata_q  <= '0;
            dmi_rvalid_q <= 1'b0;
`ifdef SBUS_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sbaddress0_q <= sbaddress0_d;
            sbdata0_q    <= sbdata0_d;
            access_q     <= access_d;
            readonaddr_q <= readonaddr_d;
            readondata_q <= readondata_d;
            autoinc_q    <= autoinc_d;
            error_q      <= error_d;
            busyerror_q  <= busyerror_d;
            sb_we_q      <= sb_we_d;
            sb_addr_q    <= sb_addr_d;
            sb_wdata_q   <= sb_wdata_d;
            sb_be_q      <= sb_be_d;
            acc_q        <= acc_d;
            lane_q       <= lane_d;
            rdata_cap_q  <= rdata_cap_d;
            err_cap_q    <= err_cap_d;
            dmi_rdata_q  <= dmi_rdata_d;
            dmi_rvalid_q <= dmi_rvalid_d;
`ifdef SBUS_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign sb_req     = (state_q == ST_REQ);
    assign sb_we      = sb_we_q;
    assign sb_addr    = sb_addr_q;
    assign sb_wdata   = sb_wdata_q;
    assign sb_be      = sb_be_q;
    assign dmi_rdata  = dmi_rdata_q;
    assign dmi_rvalid = dmi_rvalid_q;

endmodule
